pea_feeder: RTL and testbench

PEA_FEEDER -- requirements
Module: pea_feeder

---
 rtl/pea_feeder.sv | 190 +++++++++++++++++++
 tb/tb_pea_feeder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pea_feeder.sv
// ============================================================================
// Module   : pea_feeder
// Brief    : Feeds weight columns and ifm column groups into a ROWxCOL PE
//            array and generates the per-column psum-valid strobes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pea_feeder #(
    parameter int ROW       = 3,
    parameter int COL       = 8,
    parameter int WGT_WIDTH = 24,
    parameter int IFM_WIDTH = 128,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_start,
    input  logic [CNT_W-1:0]     cfg_ic_num,
    input  logic [CNT_W-1:0]     cfg_oc_num,
    input  logic [CNT_W-1:0]     cfg_ifm_w,
    input  logic                 cfg_stride,
    input  logic                 wgt_valid,
    input  logic [WGT_WIDTH-1:0] wgt_data,
    output logic                 wgt_ready,
    input  logic                 ifm_valid,
    input  logic [IFM_WIDTH-1:0] ifm_data,
    output logic                 ifm_ready,
    output logic                 wgt_read,
    output logic [WGT_WIDTH-1:0] wgt_group,
    output logic                 ifm_read,
    output logic [IFM_WIDTH-1:0] ifm_group,
    output logic [COL-1:0]       pvalid,
    output logic                 ic_done,
    output logic                 oc_done,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err
);

    localparam int                   IFM_USED = (ROW + COL - 1) * 8;
    localparam logic [IFM_WIDTH-1:0] IFM_MASK = ~({IFM_WIDTH{1'b1}} << IFM_USED);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD_WGT   = 2'd1,
        STREAM_IFM = 2'd2,
        DRAIN      = 2'd3
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     ic_num_q, oc_num_q, ifm_w_q;
    logic                 stride_q;
    logic [CNT_W-1:0]     ic_cnt_q, oc_cnt_q, col_cnt_q;
    logic [1:0]           wgt_cnt_q;
    logic [1:0]           qual_q, icd_q, ocd_q;

    logic                 wgt_read_q, ifm_read_q;
    logic [WGT_WIDTH-1:0] wgt_group_q;
    logic [IFM_WIDTH-1:0] ifm_group_q;
    logic [COL-1:0]       pvalid_q;
    logic                 ic_done_q, oc_done_q, done_q, cfg_err_q;

    logic wgt_fire, ifm_fire, col_last, qual, last_qual, ic_fin, oc_fin;

    assign wgt_ready = (state_q == LOAD_WGT);
    assign ifm_ready = (state_q == STREAM_IFM);
    assign busy      = (state_q != IDLE);

    assign wgt_fire  = wgt_valid && wgt_ready;
    assign ifm_fire  = ifm_valid && ifm_ready;
    assign col_last  = (col_cnt_q == ifm_w_q - CNT_W'(1));
    // Stride 2 keeps only even beat indices; the last kept one is w-1 or w-2.
    assign qual      = ifm_fire && (col_cnt_q >= CNT_W'(2)) && (!stride_q || !col_cnt_q[0]);
    assign last_qual = qual && (col_last || (stride_q && col_cnt_q == ifm_w_q - CNT_W'(2)));
    assign ic_fin    = last_qual && (ic_cnt_q == ic_num_q);
    assign oc_fin    = ic_fin && (oc_cnt_q == oc_num_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ic_num_q    <= '0;
            oc_num_q    <= '0;
            ifm_w_q     <= '0;
            stride_q    <= 1'b0;
            ic_cnt_q    <= '0;
            oc_cnt_q    <= '0;
            col_cnt_q   <= '0;
            wgt_cnt_q   <= '0;
            qual_q      <= '0;
            icd_q       <= '0;
            ocd_q       <= '0;
            wgt_read_q  <= 1'b0;
            ifm_read_q  <= 1'b0;
            wgt_group_q <= '0;
            ifm_group_q <= '0;
            pvalid_q    <= '0;
            ic_done_q   <= 1'b0;
            oc_done_q   <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            wgt_read_q <= wgt_fire;
            ifm_read_q <= ifm_fire;
            if (wgt_fire) wgt_group_q <= wgt_data;
            if (ifm_fire) ifm_group_q <= ifm_data & IFM_MASK;

            // Register stage plus the two-stage PE latency.
            qual_q    <= {qual_q[0], qual};
            icd_q     <= {icd_q[0], ic_fin};
            ocd_q     <= {ocd_q[0], oc_fin};
            pvalid_q  <= {COL{qual_q[1]}};
            ic_done_q <= icd_q[1];
            oc_done_q <= ocd_q[1];

            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (cfg_start) begin
                        if (cfg_ifm_w >= CNT_W'(3)) begin
                            ic_num_q  <= cfg_ic_num;
                            oc_num_q  <= cfg_oc_num;
                            ifm_w_q   <= cfg_ifm_w;
                            stride_q  <= cfg_stride;
                            ic_cnt_q  <= '0;
                            oc_cnt_q  <= '0;
                            col_cnt_q <= '0;
                            wgt_cnt_q <= '0;
                            state_q   <= LOAD_WGT;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                LOAD_WGT: begin
                    if (wgt_fire) begin
                        if (wgt_cnt_q == 2'd2) begin
                            wgt_cnt_q <= '0;
                            col_cnt_q <= '0;
                            state_q   <= STREAM_IFM;
                        end else begin
                            wgt_cnt_q <= wgt_cnt_q + 2'd1;
                        end
                    end
                end
                STREAM_IFM: begin
                    if (ifm_fire) begin
                        if (col_last) begin
                            col_cnt_q <= '0;
                            if (ic_cnt_q < ic_num_q) begin
                                ic_cnt_q <= ic_cnt_q + CNT_W'(1);
                                state_q  <= LOAD_WGT;
                            end else if (oc_cnt_q < oc_num_q) begin
                                ic_cnt_q <= '0;
                                oc_cnt_q <= oc_cnt_q + CNT_W'(1);
                                state_q  <= LOAD_WGT;
                            end else begin
                                state_q  <= DRAIN;
                            end
                        end else begin
                            col_cnt_q <= col_cnt_q + CNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (qual_q == 2'b00) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wgt_read  = wgt_read_q;
    assign wgt_group = wgt_group_q;
    assign ifm_read  = ifm_read_q;
    assign ifm_group = ifm_group_q;
    assign pvalid    = pvalid_q;
    assign ic_done   = ic_done_q;
    assign oc_done   = oc_done_q;
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;

endmodule

`default_nettype wire

// File: tb/tb_pea_feeder.sv
// ============================================================================
// Module   : tb_pea_feeder
// Brief    : Self-checking bench for pea_feeder against a beat-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pea_feeder;

    localparam int ROW       = 3;
    localparam int COL       = 8;
    localparam int WGT_WIDTH = 24;
    localparam int IFM_WIDTH = 128;
    localparam int CNT_W     = 8;
    localparam logic [IFM_WIDTH-1:0] IFM_MASK = {48'd0, {80{1'b1}}};

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cfg_start;
    logic [CNT_W-1:0]     cfg_ic_num, cfg_oc_num, cfg_ifm_w;
    logic                 cfg_stride;
    logic                 wgt_valid, wgt_ready;
    logic [WGT_WIDTH-1:0] wgt_data;
    logic                 ifm_valid, ifm_ready;
    logic [IFM_WIDTH-1:0] ifm_data;
    logic                 wgt_read, ifm_read;
    logic [WGT_WIDTH-1:0] wgt_group;
    logic [IFM_WIDTH-1:0] ifm_group;
    logic [COL-1:0]       pvalid;
    logic                 ic_done, oc_done, busy, done, cfg_err;

    always #5 clk = ~clk;

    pea_feeder #(
        .ROW(ROW), .COL(COL), .WGT_WIDTH(WGT_WIDTH), .IFM_WIDTH(IFM_WIDTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_ic_num(cfg_ic_num),
        .cfg_oc_num(cfg_oc_num), .cfg_ifm_w(cfg_ifm_w), .cfg_stride(cfg_stride),
        .wgt_valid(wgt_valid), .wgt_data(wgt_data), .wgt_ready(wgt_ready),
        .ifm_valid(ifm_valid), .ifm_data(ifm_data), .ifm_ready(ifm_ready),
        .wgt_read(wgt_read), .wgt_group(wgt_group), .ifm_read(ifm_read),
        .ifm_group(ifm_group), .pvalid(pvalid), .ic_done(ic_done), .oc_done(oc_done),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cnt_wr, cnt_ir, cnt_pv, cnt_icd, cnt_ocd, cnt_done;
    logic [WGT_WIDTH-1:0] exp_wgrp;
    logic [IFM_WIDTH-1:0] exp_igrp;

    typedef struct {
        int c;
        bit icd;
        bit ocd;
    } pv_t;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wgt_read"},  128'(wgt_read),  128'(0));
        chk({tag, "_wgt_group"}, 128'(wgt_group), 128'(0));
        chk({tag, "_ifm_read"},  128'(ifm_read),  128'(0));
        chk({tag, "_ifm_group"}, ifm_group,       128'(0));
        chk({tag, "_pvalid"},    128'(pvalid),    128'(0));
        chk({tag, "_ic_done"},   128'(ic_done),   128'(0));
        chk({tag, "_oc_done"},   128'(oc_done),   128'(0));
        chk({tag, "_busy"},      128'(busy),      128'(0));
        chk({tag, "_done"},      128'(done),      128'(0));
        chk({tag, "_cfg_err"},   128'(cfg_err),   128'(0));
        chk({tag, "_wgt_ready"}, 128'(wgt_ready), 128'(0));
        chk({tag, "_ifm_ready"}, 128'(ifm_ready), 128'(0));
    endtask

    // Runs one job; the model tracks beats per channel and derives every
    // expected strobe from the handshake cycles it has seen.
    task automatic run_job(input int icn, input int ocn, input int w, input bit stride,
                           input int vprob, input int abort_at);
        int  wl, il, ch, nch, lq, k, ibeats, done_cyc, wcyc, icyc, cyc;
        bit  ew, ei, epv, eicd, eocd, hw, hi;
        pv_t pq[$];
        pv_t e;
        cnt_wr = 0; cnt_ir = 0; cnt_pv = 0; cnt_icd = 0; cnt_ocd = 0; cnt_done = 0;
        lq = w - 1;
        if (stride && ((w - 3) % 2) != 0) lq = w - 2;
        nch = (icn + 1) * (ocn + 1);
        wl = 3; il = w; ch = 0; ibeats = 0; done_cyc = -1; wcyc = -10; icyc = -10;

        @(negedge clk);
        cfg_start  = 1'b1;
        cfg_ic_num = CNT_W'(icn);
        cfg_oc_num = CNT_W'(ocn);
        cfg_ifm_w  = CNT_W'(w);
        cfg_stride = stride;
        wgt_valid  = 1'b0;
        ifm_valid  = 1'b0;

        for (cyc = 1; cyc < 3000; cyc++) begin
            @(negedge clk);
            cfg_start = 1'b0;
            ew = (wcyc == cyc - 1);
            ei = (icyc == cyc - 1);
            epv = 1'b0; eicd = 1'b0; eocd = 1'b0;
            if (pq.size() > 0 && pq[0].c == cyc) begin
                e = pq.pop_front();
                epv = 1'b1; eicd = e.icd; eocd = e.ocd;
            end
            chk("wgt_read",  128'(wgt_read),  128'(ew));
            chk("wgt_group", 128'(wgt_group), 128'(exp_wgrp));
            chk("ifm_read",  128'(ifm_read),  128'(ei));
            chk("ifm_group", ifm_group,       exp_igrp);
            chk("pvalid",    128'(pvalid),    128'({COL{epv}}));
            chk("ic_done",   128'(ic_done),   128'(eicd));
            chk("oc_done",   128'(oc_done),   128'(eocd));
            chk("cfg_err",   128'(cfg_err),   128'(0));
            if (ch < nch) begin
                chk("busy",      128'(busy),      128'(1));
                chk("wgt_ready", 128'(wgt_ready), 128'(wl > 0));
                chk("ifm_ready", 128'(ifm_ready), 128'(wl == 0));
            end
            cnt_wr  += int'(wgt_read);
            cnt_ir  += int'(ifm_read);
            cnt_pv  += int'(pvalid == {COL{1'b1}});
            cnt_icd += int'(ic_done);
            cnt_ocd += int'(oc_done);
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                chk("done_single", 128'(done), 128'(0));
                chk("busy_after_done", 128'(busy), 128'(0));
                break;
            end
            if (done === 1'b1) begin
                cnt_done++;
                chk("done_after_all_pvalid", 128'(pq.size() == 0 && ch == nch), 128'(1));
                done_cyc = cyc;
            end

            if (abort_at >= 0 && ibeats == abort_at) begin
                rst = 1'b1;
                wgt_valid = 1'b0;
                ifm_valid = 1'b0;
                #1;
                chk_all_zero("rst_async");
                @(negedge clk);
                rst = 1'b0;
                exp_wgrp = '0;
                exp_igrp = '0;
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    chk("post_rst_done",    128'(done),    128'(0));
                    chk("post_rst_pvalid",  128'(pvalid),  128'(0));
                    chk("post_rst_ic_done", 128'(ic_done), 128'(0));
                    chk("post_rst_busy",    128'(busy),    128'(0));
                end
                return;
            end

            // A start request while busy must have no effect.
            if (cyc == 2) begin
                cfg_start  = 1'b1;
                cfg_ifm_w  = CNT_W'($urandom_range(3, 9));
                cfg_ic_num = CNT_W'($urandom_range(0, 3));
            end
            wgt_valid = ($urandom_range(0, 99) < vprob);
            wgt_data  = WGT_WIDTH'($urandom);
            ifm_valid = ($urandom_range(0, 99) < vprob);
            ifm_data  = {$urandom, $urandom, $urandom, $urandom};
            hw = wgt_valid && (ch < nch) && (wl > 0);
            hi = ifm_valid && (ch < nch) && (wl == 0);
            if (hw) begin
                wl--;
                wcyc = cyc;
                exp_wgrp = wgt_data;
            end
            if (hi) begin
                k = w - il;
                if (k >= 2 && (!stride || ((k - 2) % 2) == 0)) begin
                    e.c   = cyc + 3;
                    e.icd = (k == lq) && ((ch % (icn + 1)) == icn);
                    e.ocd = e.icd && (ch == nch - 1);
                    pq.push_back(e);
                end
                icyc = cyc;
                exp_igrp = ifm_data & IFM_MASK;
                ibeats++;
                il--;
                if (il == 0) begin
                    ch++;
                    wl = 3;
                    il = w;
                end
            end
        end
        cfg_start = 1'b0;
        wgt_valid = 1'b0;
        ifm_valid = 1'b0;
        chk("job_completed", 128'(done_cyc >= 0), 128'(1));
        chk("done_count", 128'(cnt_done), 128'(1));
    endtask

    initial begin
        rst = 1'b1;
        cfg_start = 1'b0; cfg_ic_num = '0; cfg_oc_num = '0; cfg_ifm_w = '0; cfg_stride = 1'b0;
        wgt_valid = 1'b0; wgt_data = '0; ifm_valid = 1'b0; ifm_data = '0;
        exp_wgrp = '0; exp_igrp = '0;
        @(negedge clk);
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("idle");

        // One channel, five columns, stride 1, streams always valid.
        run_job(0, 0, 5, 1'b0, 100, -1);
        chk("j1_wgt_reads", 128'(cnt_wr), 128'(3));
        chk("j1_ifm_reads", 128'(cnt_ir), 128'(5));
        chk("j1_pvalids",   128'(cnt_pv), 128'(3));
        chk("j1_ic_done",   128'(cnt_icd), 128'(1));
        chk("j1_oc_done",   128'(cnt_ocd), 128'(1));

        // Stride 2, six columns: windows at beats 2 and 4 only.
        run_job(0, 0, 6, 1'b1, 100, -1);
        chk("j2_pvalids", 128'(cnt_pv), 128'(2));
        chk("j2_ic_done", 128'(cnt_icd), 128'(1));

        // Two input channels by two output tiles.
        run_job(1, 1, 4, 1'b0, 100, -1);
        chk("j3_wgt_reads", 128'(cnt_wr), 128'(12));
        chk("j3_ifm_reads", 128'(cnt_ir), 128'(16));
        chk("j3_pvalids",   128'(cnt_pv), 128'(8));
        chk("j3_ic_done",   128'(cnt_icd), 128'(2));
        chk("j3_oc_done",   128'(cnt_ocd), 128'(1));

        // Randomly stalled streams.
        run_job(1, 0, 7, 1'b1, 50, -1);
        chk("j4_pvalids", 128'(cnt_pv), 128'(6));
        run_job(2, 1, 5, 1'b0, 60, -1);
        chk("j5_pvalids", 128'(cnt_pv), 128'(18));
        chk("j5_ic_done", 128'(cnt_icd), 128'(2));

        // Illegal width: error pulse, job never starts.
        @(negedge clk);
        cfg_start = 1'b1;
        cfg_ifm_w = CNT_W'(2);
        @(negedge clk);
        cfg_start = 1'b0;
        chk("cfg_err_pulse", 128'(cfg_err), 128'(1));
        chk("cfg_err_busy",  128'(busy),    128'(0));
        @(negedge clk);
        chk("cfg_err_clear", 128'(cfg_err), 128'(0));
        chk("cfg_err_busy2", 128'(busy),    128'(0));

        // Abort mid-stream, then a clean job.
        run_job(0, 1, 6, 1'b0, 100, 3);
        run_job(0, 1, 6, 1'b0, 70, -1);
        chk("j7_pvalids", 128'(cnt_pv), 128'(8));
        chk("j7_oc_done", 128'(cnt_ocd), 128'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
